dmem_responder: RTL and testbench

Wait-state data-memory responder: the memory end of the CPU's load/store data port. Accepts one word-aligned read or write request at a time over a valid/ready handshake, commits it to an internal word array after a programmable number of wait cycles, and returns read data plus an error flag over a second valid/ready handshake. It replaces the zero-latency data memory when the datapath is run with a stalling memory interface.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory end of the CPU load/store data port. One word-aligned request is
// accepted at a time. After LATENCY wait cycles it is committed to the
// internal word array. Read data and an error flag are then returned over a
// second valid/ready handshake.
//
// Parameters
//   ADDR_W   word-address width; the array holds 2^ADDR_W words
//   LATENCY  wait cycles between accept and commit (0..15)
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   reset      synchronous, active-high
//   req_valid  request present            req_ready  responder idle
//   req_addr   byte address               req_we     1 = store, 0 = load
//   req_be     store byte-lane enables    req_wdata  store data
//   rsp_valid  response present           rsp_ready  CPU takes the response
//   rsp_rdata  load data (0 for stores and errors)
//   rsp_err    misaligned or out-of-range access
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT    = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Word array; contents survive reset.
  logic [31:0] mem [0:DEPTH-1];

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic              w_accept;
  logic              w_commit;
  logic [31:0]       w_c_addr;
  logic              w_c_we;
  logic [3:0]        w_c_be;
  logic [31:0]       w_c_wdata;
  logic              w_c_err;
  logic [ADDR_W-1:0] w_c_idx;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // With zero latency the request commits on its accept edge, straight from
  // the input bus; otherwise it commits on the edge the counter hits zero,
  // from the latched copy. Reset blocks the commit so a dropped store never
  // reaches the array.
  assign w_commit = !reset &&
                    ((w_accept && (LAT == 4'd0)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd1)));

  assign w_c_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_c_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_c_be    = (r_state == S_IDLE) ? req_be    : r_be;
  assign w_c_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_c_err = (|w_c_addr[1:0]) || (|w_c_addr[31:ADDR_W+2]);
  assign w_c_idx = w_c_addr[ADDR_W+1:2];

  // Handshake outputs come from registered state only; reset forces the
  // request side closed while it is held.
  assign req_ready = (r_state == S_IDLE) && !reset;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cnt   <= LAT;
            r_state <= (LAT == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_commit) begin
        r_err   <= w_c_err;
        r_rdata <= (w_c_err || w_c_we) ? 32'd0 : mem[w_c_idx];
      end
    end
  end

  // Request fields are captured on accept only and need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= req_addr;
      r_we    <= req_we;
      r_be    <= req_be;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_c_we && !w_c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_c_be[i]) begin
          mem[w_c_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  // LATENCY = 2 instance
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  // LATENCY = 0 instance
  logic        rst0;
  logic        req_valid0, req_ready0, req_we0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_be0;
  logic        rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int n_cmp;
  int n_bad;

  dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst0),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
    .req_we(req_we0), .req_be(req_be0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction on the LATENCY=2 instance. lat = number of
  // negedges after the accept edge on which rsp_valid was still low.
  task automatic xact(input logic [31:0] a, input logic we, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat);
    int n;
    @(negedge clk);
    req_addr = a; req_we = we; req_be = be; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_req_ready_in_reset got=%b exp=0", req_ready);
    end
    n_cmp++;
    if (req_ready0 !== 1'b0) begin
      n_bad++; $display("FAIL rst0_req_ready_in_reset got=%b exp=0", req_ready0);
    end
    rst = 1'b0; rst0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready);
    end
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid);
    end
    n_cmp++;
    if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_rsp_data got=%h/%b exp=00000000/0", rsp_rdata, rsp_err);
    end
    n_cmp++;
    if (rsp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
      n_bad++; $display("FAIL rst0_handshake got v=%b r=%b exp v=0 r=1", rsp_valid0, req_ready0);
    end
  endtask

  task automatic test_load;
    logic [31:0] rd; logic er; int lat;
    xact(32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, rd, er, lat);
    xact(32'h0000_0020, 1'b1, 4'hF, 32'hAABB_CCDD, rd, er, lat);
    xact(32'h0000_0000, 1'b1, 4'hF, 32'h0BAD_C0DE, rd, er, lat);
    xact(32'h0000_0010, 1'b0, 4'h0, 32'h0, rd, er, lat);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL load_latency got=%0d exp=2", lat);
    end
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      n_bad++; $display("FAIL load_data got=%h/%b exp=deadbeef/0", rd, er);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL load_after_hs got v=%b r=%b exp v=0 r=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_store_be;
    logic [31:0] rd; logic er; int lat;
    xact(32'h0000_0020, 1'b1, 4'b0101, 32'h1122_3344, rd, er, lat);
    n_cmp++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin
      n_bad++; $display("FAIL store_rsp got=%h/%b lat=%0d exp=00000000/0 lat=2", rd, er, lat);
    end
    xact(32'h0000_0020, 1'b0, 4'h0, 32'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'hAA22_CC44 || er !== 1'b0) begin
      n_bad++; $display("FAIL store_be_merge got=%h/%b exp=aa22cc44/0", rd, er);
    end
    xact(32'h0000_0020, 1'b1, 4'b0000, 32'hFFFF_FFFF, rd, er, lat);
    xact(32'h0000_0020, 1'b0, 4'h0, 32'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'hAA22_CC44) begin
      n_bad++; $display("FAIL store_be_none got=%h exp=aa22cc44", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    xact(32'h0000_0006, 1'b0, 4'h0, 32'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      n_bad++; $display("FAIL err_misaligned_load got=%h/%b exp=00000000/1", rd, er);
    end
    xact(32'h0000_1000, 1'b1, 4'hF, 32'hFFFF_FFFF, rd, er, lat);
    n_cmp++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      n_bad++; $display("FAIL err_oor_store got=%h/%b exp=00000000/1", rd, er);
    end
    xact(32'h0000_0002, 1'b1, 4'hF, 32'h5555_5555, rd, er, lat);
    n_cmp++;
    if (er !== 1'b1) begin
      n_bad++; $display("FAIL err_misaligned_store got=%b exp=1", er);
    end
    xact(32'h0000_0000, 1'b0, 4'h0, 32'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0BAD_C0DE || er !== 1'b0) begin
      n_bad++; $display("FAIL err_array_unchanged got=%h/%b exp=0badc0de/0", rd, er);
    end
  endtask

  task automatic test_stall;
    logic [31:0] rd; logic er; int lat; int n;
    @(negedge clk);
    req_addr = 32'h0000_0010; req_we = 1'b0; req_be = 4'h0; req_wdata = 32'h0;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_addr = 32'h0000_0010; req_we = 1'b1; req_be = 4'hF; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_handshake cyc=%0d got v=%b r=%b exp v=1 r=0", i, rsp_valid, req_ready);
      end
      n_cmp++;
      if (rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
        n_bad++; $display("FAIL stall_data cyc=%0d got=%h/%b exp=deadbeef/0", i, rsp_rdata, rsp_err);
      end
      req_valid = (i % 2 == 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    xact(32'h0000_0010, 1'b0, 4'h0, 32'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL stall_req_ignored got=%h exp=deadbeef", rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] oa [6];
    logic        ow [6];
    logic [31:0] od [6];
    logic [31:0] ex [6];
    int ni, nr, last;
    oa = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8};
    ow = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    od = '{32'hA0A0_A0A0, 32'hA1A1_A1A1, 32'hA2A2_A2A2, 32'h0, 32'h0, 32'h0};
    ex = '{32'h0, 32'h0, 32'h0, 32'hA0A0_A0A0, 32'hA1A1_A1A1, 32'hA2A2_A2A2};
    ni = 0; nr = 0; last = 0;
    rsp_ready0 = 1'b1;
    for (int cyc = 0; cyc < 40 && nr < 6; cyc++) begin
      @(negedge clk);
      if (rsp_valid0) begin
        n_cmp++;
        if (rsp_rdata0 !== ex[nr] || rsp_err0 !== 1'b0) begin
          n_bad++; $display("FAIL b2b_data idx=%0d got=%h/%b exp=%h/0", nr, rsp_rdata0, rsp_err0, ex[nr]);
        end
        if (nr > 0) begin
          n_cmp++;
          if (cyc - last != 2) begin
            n_bad++; $display("FAIL b2b_period idx=%0d got=%0d exp=2", nr, cyc - last);
          end
        end
        last = cyc;
        nr++;
      end
      if (req_ready0) begin
        if (ni < 6) begin
          req_addr0 = oa[ni]; req_we0 = ow[ni]; req_be0 = 4'hF; req_wdata0 = od[ni];
          req_valid0 = 1'b1;
          ni++;
        end else begin
          req_valid0 = 1'b0;
        end
      end
    end
    req_valid0 = 1'b0;
    n_cmp++;
    if (nr != 6) begin
      n_bad++; $display("FAIL b2b_count got=%0d exp=6", nr);
    end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd; logic er; int lat; int seen;
    @(negedge clk);
    req_addr = 32'h0; req_we = 1'b1; req_be = 4'hF; req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstwait_in_reset got r=%b v=%b exp r=0 v=0", req_ready, rsp_valid);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    n_cmp++;
    if (seen != 0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstwait_no_rsp got rsp=%0d r=%b exp rsp=0 r=1", seen, req_ready);
    end
    rsp_ready = 1'b0;
    xact(32'h0000_0000, 1'b0, 4'h0, 32'h0, rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0BAD_C0DE) begin
      n_bad++; $display("FAIL rstwait_mem_unchanged got=%h exp=0badc0de", rd);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; rst0 = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
    rsp_ready = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_be0 = 4'h0; req_addr0 = 32'h0; req_wdata0 = 32'h0;
    rsp_ready0 = 1'b0;
    test_reset();
    test_load();
    test_store_be();
    test_errors();
    test_stall();
    test_back_to_back();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
